// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO of renameable IDs, one allocation and two releases per cycle.
// Optional FREELIST_BYPASS_EN: when the list is empty, an allocation is served directly from release port 0.
module preg_free_list #(
    parameter int NUM_FREE  = 32,
    parameter int PREG_W    = 6,
    parameter int PREG_BASE = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic [1:0]        rel_valid,
    input  logic [PREG_W-1:0] rel_preg0,
    input  logic [PREG_W-1:0] rel_preg1,
    output logic [PREG_W-1:0] free_cnt,
    output logic              stall,
    output logic              ovf_err
);

    localparam int PTR_W = (NUM_FREE > 1) ? $clog2(NUM_FREE) : 1;

    logic [PREG_W-1:0] mem [NUM_FREE];
    logic [PTR_W-1:0]  head, tail, tail1, tail_next;
    logic [PREG_W-1:0] count, count_next;
    logic              ovf_q;

    logic              nonempty, legal0, legal1, bypass, fifo_gnt;
    logic              acc0, acc1, rel_err;
    logic [PREG_W:0]   space;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_FREE - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign nonempty = (count != '0);
    assign legal0   = rel_valid[0] && (rel_preg0 >= PREG_W'(PREG_BASE));
    assign legal1   = rel_valid[1] && (rel_preg1 >= PREG_W'(PREG_BASE));

`ifdef FREELIST_BYPASS_EN
    assign bypass = rstn && alloc_req && !nonempty && legal0;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_gnt   = rstn && alloc_req && nonempty;
    assign alloc_gnt  = fifo_gnt || bypass;
    assign alloc_preg = bypass ? rel_preg0 : (nonempty ? mem[head] : '0);
    assign stall      = rstn && !nonempty && !bypass;
    assign free_cnt   = count;
    assign ovf_err    = ovf_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc0       = 1'b0;
        acc1       = 1'b0;
        rel_err    = 1'b0;
        // Slots usable this cycle: the one being popped by a grant is reusable immediately.
        space      = (PREG_W + 1)'(NUM_FREE) - {1'b0, count} + {{PREG_W{1'b0}}, fifo_gnt};
        acc0       = legal0 && !bypass && (space != '0);
        acc1       = legal1 && (acc0 ? (space >= (PREG_W + 1)'(2)) : (space != '0));
        rel_err    = (rel_valid[0] && !legal0) || (rel_valid[1] && !legal1) ||
                     (legal0 && !bypass && !acc0) || (legal1 && !acc1);
        tail1      = acc0 ? ptr_inc(tail) : tail;
        tail_next  = acc1 ? ptr_inc(tail1) : tail1;
        count_next = count - PREG_W'(fifo_gnt) + PREG_W'(acc0) + PREG_W'(acc1);
    end

    // NOTE: the storage array is reset on purpose -- the free list must start populated with every renameable ID.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_FREE; i++) mem[i] <= PREG_W'(PREG_BASE + i);
            head  <= '0;
            tail  <= '0;
            count <= PREG_W'(NUM_FREE);
            ovf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (acc0) mem[tail]  <= rel_preg0;
            if (acc1) mem[tail1] <= rel_preg1;
            if (fifo_gnt) head   <= ptr_inc(head);
            tail  <= tail_next;
            count <= count_next;
            if (rel_err) ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list: directed scenarios plus randomized traffic against a queue model.
module tb_preg_free_list;

    localparam int NF = 32;
    localparam int PW = 6;
    localparam int PB = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [PW-1:0] alloc_preg;
    logic [1:0]    rel_valid;
    logic [PW-1:0] rel_preg0;
    logic [PW-1:0] rel_preg1;
    logic [PW-1:0] free_cnt;
    logic          stall;
    logic          ovf_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the free list is an ordered queue of IDs plus a sticky error bit.
    int q[$];
    bit ovf;

    preg_free_list #(.NUM_FREE(NF), .PREG_W(PW), .PREG_BASE(PB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_preg(alloc_preg),
        .rel_valid (rel_valid),
        .rel_preg0 (rel_preg0),
        .rel_preg1 (rel_preg1),
        .free_cnt  (free_cnt),
        .stall     (stall),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NF; i++) q.push_back(PB + i);
        ovf = 1'b0;
    endtask

    task automatic model_release(input int id, input bit consumed);
        if (id < PB) ovf = 1'b1;
        else if (!consumed) begin
            if (q.size() < NF) q.push_back(id);
            else ovf = 1'b1;
        end
    endtask

    // One clock: drive after the edge, check at the falling edge, then advance the model.
    task automatic cycle(input bit r, input bit [1:0] v, input int a, input int b);
        bit byp;
        bit fg;
        int exp_preg;
        alloc_req = r;
        rel_valid = v;
        rel_preg0 = a[PW-1:0];
        rel_preg1 = b[PW-1:0];
        @(negedge clk);
        byp = 1'b0;
`ifdef FREELIST_BYPASS_EN
        byp = rstn && r && (q.size() == 0) && v[0] && (a >= PB);
`endif
        fg = rstn && r && (q.size() != 0);
        if (byp) exp_preg = a;
        else if (q.size() != 0) exp_preg = q[0];
        else exp_preg = 0;
        check("alloc_gnt", alloc_gnt, fg || byp);
        check("alloc_preg", alloc_preg, exp_preg);
        check("stall", stall, rstn && (q.size() == 0) && !byp);
        check("free_cnt", free_cnt, q.size());
        check("ovf_err", ovf_err, ovf);
        if (!rstn) model_reset();
        else begin
            if (fg) void'(q.pop_front());
            if (v[0]) model_release(a, byp);
            if (v[1]) model_release(b, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cycle(1'b0, 2'b00, 0, 0);
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        alloc_req = 1'b0;
        rel_valid = 2'b00;
        rel_preg0 = '0;
        rel_preg1 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // Reset state, with a request that must be ignored while rstn is low.
        cycle(1'b1, 2'b11, 40, 41);
        check("rst_free_cnt", free_cnt, NF);
        check("rst_alloc_preg", alloc_preg, PB);
        rstn = 1'b1;

        // Drain the whole list in order, then observe the stall.
        for (int i = 0; i < NF; i++) cycle(1'b1, 2'b00, 0, 0);
        check("drained_cnt", free_cnt, 0);
        cycle(1'b1, 2'b00, 0, 0);
        check("empty_stall", stall, 1);

        // Dual release into an empty list, then two grants in port order.
        cycle(1'b0, 2'b11, 40, 45);
        check("dual_rel_cnt", free_cnt, 2);
        cycle(1'b1, 2'b00, 0, 0);
        cycle(1'b1, 2'b00, 0, 0);
        check("dual_rel_drain", free_cnt, 0);

        // Simultaneous allocate and release with five free entries.
        cycle(1'b0, 2'b11, 41, 42);
        cycle(1'b0, 2'b11, 43, 44);
        cycle(1'b0, 2'b01, 46, 0);
        check("five_free", free_cnt, 5);
        cycle(1'b1, 2'b01, 50, 0);
        check("alloc_rel_cnt", free_cnt, 5);
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'b00, 0, 0);

        // Overflow on a full list, then an illegal ID release.
        do_reset();
        cycle(1'b0, 2'b01, 33, 0);
        check("ovf_full_cnt", free_cnt, NF);
        check("ovf_full_flag", ovf_err, 1);
        cycle(1'b1, 2'b00, 0, 0);
        check("ovf_sticky", ovf_err, 1);
        do_reset();
        cycle(1'b0, 2'b01, 0, 0);
        check("ovf_p0_flag", ovf_err, 1);

        // Pointer wrap with a full list and steady allocate+release traffic.
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, 2'b01, int'($urandom_range(PB, 63)), 0);
        for (int i = 0; i < NF + 1; i++) cycle(1'b1, 2'b00, 0, 0);

        // Allocation arriving while empty with a same-cycle release.
        do_reset();
        for (int i = 0; i < NF; i++) cycle(1'b1, 2'b00, 0, 0);
        alloc_req = 1'b1;
        rel_valid = 2'b01;
        rel_preg0 = PW'(61);
        #1;
`ifdef FREELIST_BYPASS_EN
        check("byp_gnt", alloc_gnt, 1);
        check("byp_preg", alloc_preg, 61);
        check("byp_stall", stall, 0);
`else
        check("nobyp_gnt", alloc_gnt, 0);
        check("nobyp_stall", stall, 1);
`endif
        cycle(1'b1, 2'b01, 61, 0);
`ifdef FREELIST_BYPASS_EN
        check("byp_cnt", free_cnt, 0);
`else
        check("nobyp_cnt", free_cnt, 1);
`endif

        // Randomized traffic with phase-varying allocation pressure and rare resets.
        for (int ph = 0; ph < 15; ph++) begin
            int pct;
            pct = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 20 : 50);
            for (int i = 0; i < 200; i++) begin
                bit r;
                bit [1:0] v;
                int a;
                int b;
                rstn = ($urandom_range(0, 249) != 0);
                r = ($urandom_range(0, 99) < pct);
                v = 2'($urandom_range(0, 3));
                a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, PB - 1)) : int'($urandom_range(PB, 63));
                b = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, PB - 1)) : int'($urandom_range(PB, 63));
                cycle(r, v, a, b);
            end
            rstn = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 SHALL have parameter NUM_FREE, default 32, meaning the number of renameable physical registers held in the free list.
REQ-002 SHALL have parameter PREG_W, default 6, meaning the physical register ID width.
REQ-003 SHALL have parameter PREG_BASE, default 32, meaning the first renameable physical register ID.
REQ-004 SHALL have port clk, input, 1 bit: the clock.
REQ-005 SHALL have port rstn, input, 1 bit: the reset, which is synchronous and active-low.
REQ-006 SHALL have port alloc_req, input, 1 bit: rename requests one destination register this cycle.
REQ-007 SHALL have port alloc_gnt, output, 1 bit: the allocation is granted this cycle.
REQ-008 SHALL have port alloc_preg, output, PREG_W bits: the granted physical register ID.
REQ-009 SHALL have port rel_valid, input, 2 bits: per-port retire-release strobes from the ROB.
REQ-010 SHALL have ports rel_preg0 and rel_preg1, input, PREG_W bits each: the physical register IDs being freed.
REQ-011 SHALL have port free_cnt, output, PREG_W bits: the current number of free entries (0..NUM_FREE).
REQ-012 SHALL have port stall, output, 1 bit: a rename stall, asserted when no register is available.
REQ-013 SHALL have port ovf_err, output, 1 bit: sticky flag indicating an overflow or illegal release.

Function
REQ-014 SHALL store free IDs in a circular FIFO of NUM_FREE entries, with head and tail pointers of log2(NUM_FREE) bits wrapping modulo NUM_FREE, and a count register.
REQ-015 SHALL drive alloc_gnt = alloc_req AND (count != 0) combinationally, with zero-cycle latency.
REQ-016 SHALL drive alloc_preg = mem[head] when count != 0, and 0 otherwise; the value is valid in the same cycle as alloc_gnt.
REQ-017 SHALL advance head by 1 on a clock edge where alloc_gnt = 1.
REQ-018 SHALL, when rel_valid[0] is set, write rel_preg0 at tail. When rel_valid[1] is set, it SHALL write rel_preg1 at tail+1 if port 0 is also valid, else at tail. Tail SHALL advance by the number of accepted releases.
REQ-019 SHALL treat a release of an ID below PREG_BASE (including p0) as not accepted: no write, and ovf_err is set.
REQ-020 SHALL update count as count_next = count - alloc_gnt + accepted releases. Allocation and release in the same cycle SHALL both take effect.
REQ-021 SHALL drop any release that would make count_next exceed NUM_FREE, and SHALL set ovf_err. When both ports are valid and only one slot is free, port 0 SHALL win.
REQ-022 SHALL never expose a same-cycle release at the head: a newly released ID becomes allocatable no earlier than the next cycle, except as stated in REQ-028.
REQ-023 SHALL drive stall = (count == 0) combinationally, independent of alloc_req.
REQ-024 SHALL drive free_cnt = count, registered.
REQ-025 SHALL keep ovf_err asserted until reset once it is set.

Reset
REQ-026 SHALL, when rstn = 0 at a clock edge, load mem[i] = PREG_BASE + i, head = 0, tail = 0, count = NUM_FREE, and ovf_err = 0. Releases and allocations in that cycle SHALL be ignored.
REQ-027 SHALL, under reset, drive outputs alloc_gnt = 0, stall = 0, free_cnt = NUM_FREE, and alloc_preg = PREG_BASE (after the reset edge). Reset asserted mid-operation SHALL discard all in-flight state.

Configuration
REQ-028 SHALL, with FREELIST_BYPASS_EN defined, satisfy an allocation that arrives while count == 0 and rel_valid[0] = 1 (with a legal ID) directly from the release: alloc_gnt = 1, alloc_preg = rel_preg0, port 0 not enqueued, and stall = 0 that cycle.
REQ-029 SHALL, without FREELIST_BYPASS_EN, grant and stall strictly from count as in REQ-015 and REQ-023.

Verification
REQ-030 SHALL cover: reset, then alloc_req held for 32 cycles -> alloc_preg = 32, 33, ..., 63 in order; free_cnt reaches 0; stall = 1 on cycle 33.
REQ-031 SHALL cover: list empty, rel_valid = 2'b11 with IDs 40 and 45 -> next cycle free_cnt = 2; the next two grants return 40, then 45.
REQ-032 SHALL cover: free_cnt = 5, alloc_req = 1 and rel_valid = 2'b01 (ID 50) in the same cycle -> free_cnt = 5; 50 is enqueued at the tail.
REQ-033 SHALL cover: list full (32), rel_valid = 2'b01 with ID 33 -> release dropped, free_cnt = 32, ovf_err = 1 and remaining set; a release of ID 0 also sets ovf_err.
REQ-034 SHALL cover pointer wrap: 40 allocations interleaved with 40 releases -> FIFO order preserved across the head/tail wrap at 31 -> 0.
REQ-035 SHALL cover bypass: count = 0, alloc_req = 1, rel_valid = 2'b01 with ID 61 -> with FREELIST_BYPASS_EN, alloc_gnt = 1, alloc_preg = 61, free_cnt stays 0; without it, alloc_gnt = 0, stall = 1, and free_cnt = 1 next cycle.
